// File: rtl/des_pkg.sv
// des_pkg: FSM state type, key-rotation schedule, DES permutation tables,
// S-box contents and the helpers that apply them.
// Bit numbering follows DES throughout: DES bit 1 is the MSB of each vector.
package des_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} des_state_e;

    // Left-rotation amount for rounds 1..16 (index 0 = round 1)
    localparam logic [1:0] SHIFTS [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                           2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    localparam int unsigned IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                          62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                          57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                          61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int unsigned FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                          38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                          36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                          34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int unsigned E_T [48]  = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,
                                          12,13,14,15,16,17,16,17,18,19,20,21,20,21,22,23,24,25,
                                          24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int unsigned P_T [32]  = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                          2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int unsigned PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,
                                           10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                           63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                                           14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int unsigned PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,
                                           23,19,12,4,26,8,16,7,27,20,13,2,
                                           41,52,31,37,47,55,30,40,51,45,33,48,
                                           44,49,39,56,34,53,46,42,50,36,29,32};

    // Each S-box packed row-major, entry (row*16+col) at nibble 0 = MSB
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[63-j] = x[64-IP_T[j]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[63-j] = x[64-FP_T[j]];
        return y;
    endfunction

    function automatic logic [47:0] e_perm(input logic [31:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[47-j] = x[32-E_T[j]];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int j = 0; j < 32; j++) y[31-j] = x[32-P_T[j]];
        return y;
    endfunction

    // Parity bits (DES bits 8,16,..,64) are simply never selected
    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int j = 0; j < 56; j++) y[55-j] = x[64-PC1_T[j]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[47-j] = x[56-PC2_T[j]];
        return y;
    endfunction

    // Row from the outer bits, column from the inner four
    function automatic logic [3:0] sbox_lookup(input int unsigned box, input logic [5:0] b);
        logic [5:0] pos;
        pos = {b[5], b[0], b[4:1]};
        return SBOX[box][255 - 4 * int'(pos) -: 4];
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    // Key-register update for the round at schedule index idx (0 = round 1).
    // Decrypt walks the schedule backwards, so it undoes s(17-r).
    function automatic logic [55:0] cd_step(input logic [55:0] cd, input logic dec,
                                            input logic [3:0] idx);
        logic [1:0] s;
        s = dec ? SHIFTS[4'd15 - idx] : SHIFTS[idx];
        return dec ? {rotr28(cd[55:28], s), rotr28(cd[27:0], s)}
                   : {rotl28(cd[55:28], s), rotl28(cd[27:0], s)};
    endfunction

    // Encrypt uses the freshly rotated C,D; decrypt uses C,D before rotating
    function automatic logic [47:0] round_key(input logic [55:0] cd, input logic dec,
                                              input logic [3:0] idx);
        return pc2_perm(dec ? cd : cd_step(cd, 1'b0, idx));
    endfunction

endpackage

// File: rtl/des_f_func.sv
// des_f_func: combinational DES round function f(R, K) = P(S(E(R) ^ K)).
module des_f_func
    import des_pkg::*;
(
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);

    logic [47:0] x;
    logic [31:0] s;

    assign x = e_perm(r_i) ^ k_i;

    for (genvar i = 0; i < 8; i++) begin : g_sbox
        des_sbox #(.IDX(i)) u_sbox (
            .b_i (x[47-6*i -: 6]),
            .s_o (s[31-4*i -: 4])
        );
    end

    assign f_o = p_perm(s);

endmodule

// File: rtl/des_sbox.sv
// des_sbox: one 6-to-4 DES substitution box, selected by IDX (0 = S1).
module des_sbox
    import des_pkg::*;
#(
    parameter int unsigned IDX = 0
) (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);

    assign s_o = sbox_lookup(IDX, b_i);

endmodule

// File: rtl/des_iter_core.sv
// des_iter_core: iterative single-DES engine with valid/ready on both sides.
// One Feistel round per clock (16-clock latency) by default. Defining
// DES_TWO_ROUNDS_EN chains two round functions per clock (8-clock latency);
// NUM_ROUNDS must then be even.
module des_iter_core
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic        i_decrypt,
    input  logic [63:0] i_key,
    input  logic [63:0] i_text,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [63:0] o_text
);

    localparam int CNT_W = $clog2(NUM_ROUNDS + 1);

    des_state_e       state_q;
    logic             in_ready_q, out_valid_q, dec_q;
    logic [63:0]      text_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      l_q, r_q, l_d, r_d;
    logic [55:0]      cd_q, cd_d;

    logic [3:0]  idx0;
    logic [47:0] k0;
    logic [55:0] cd1;
    logic [31:0] f0, l1, r1;

    assign idx0 = cnt_q[3:0];
    assign k0   = round_key(cd_q, dec_q, idx0);
    assign cd1  = cd_step(cd_q, dec_q, idx0);

    des_f_func u_f0 (.r_i(r_q), .k_i(k0), .f_o(f0));

    assign l1 = r_q;
    assign r1 = l_q ^ f0;

`ifdef DES_TWO_ROUNDS_EN
    localparam int STEP = 2;

    logic [3:0]  idx1;
    logic [47:0] k1;
    logic [31:0] f1;

    assign idx1 = idx0 + 4'd1;
    assign k1   = round_key(cd1, dec_q, idx1);

    des_f_func u_f1 (.r_i(r1), .k_i(k1), .f_o(f1));

    assign l_d  = r1;
    assign r_d  = l1 ^ f1;
    assign cd_d = cd_step(cd1, dec_q, idx1);
`else
    localparam int STEP = 1;

    assign l_d  = l1;
    assign r_d  = r1;
    assign cd_d = cd1;
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ROUNDS - STEP);

    // Handshake FSM plus round datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            text_q      <= '0;
            cnt_q       <= '0;
            dec_q       <= 1'b0;
            l_q         <= '0;
            r_q         <= '0;
            cd_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_in_valid) begin
                        {l_q, r_q} <= ip_perm(i_text);
                        cd_q       <= pc1_perm(i_key);
                        dec_q      <= i_decrypt;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    l_q   <= l_d;
                    r_q   <= r_d;
                    cd_q  <= cd_d;
                    cnt_q <= cnt_q + CNT_W'(STEP);
                    if (cnt_q == LAST) begin
                        // Final swap: output is FP(R16 || L16)
                        text_q      <= fp_perm({r_d, l_d});
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_in_ready  = in_ready_q;
    assign o_out_valid = out_valid_q;
    assign o_text      = text_q;

endmodule

// File: tb/tb_des_iter_core.sv
// tb_des_iter_core: scoreboard bench for des_iter_core. Known-answer vectors,
// backpressure, mid-run reset, and random blocks against a textbook DES model
// (precomputed subkey list, reversed for decryption).
module tb_des_iter_core;
    import des_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic        i_decrypt = 1'b0;
    logic [63:0] i_key = '0;
    logic [63:0] i_text = '0;
    logic        o_out_valid;
    logic        i_out_ready = 1'b1;
    logic [63:0] o_text;

    typedef struct {
        logic [63:0] txt;
        int          hs;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   have_cur = 0;
    bit   prev_v = 0;
    int   n_cmp = 0, n_bad = 0, cyc = 0, rdy_mode = 0;
    int   SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    des_iter_core #(.NUM_ROUNDS(16)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_decrypt   (i_decrypt),
        .i_key       (i_key),
        .i_text      (i_text),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_text      (o_text)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Reference model: textbook DES
    function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        x = e_perm(r) ^ k;
        for (int b = 0; b < 8; b++) s[31-4*b -: 4] = sbox_lookup(b, x[47-6*b -: 6]);
        return p_perm(s);
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] text,
                                              input logic dec);
        logic [47:0] ks [16];
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [63:0] x;
        logic [31:0] l, r, t;
        cd = pc1_perm(key);
        c  = cd[55:28];
        d  = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < SH[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i] = pc2_perm({c, d});
        end
        x = ip_perm(text);
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ f_model(r, dec ? ks[15-i] : ks[i]);
            l = t;
        end
        return fp_perm({r, l});
    endfunction

    // Downstream ready: 0 = always ready, 1 = random stalls, 2 = held low
    always @(negedge i_clk) begin
        case (rdy_mode)
            0:       i_out_ready = 1'b1;
            1:       i_out_ready = ($urandom_range(0, 3) != 0);
            default: i_out_ready = 1'b0;
        endcase
    end

    // Monitor: pop on each new result, then check it holds while presented
    always @(negedge i_clk) begin
        if (o_out_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                fail("unexpected_output");
                have_cur = 0;
            end else begin
                cur = exp_q.pop_front();
                have_cur = 1;
                chk("result", o_text, cur.txt);
                chk("latency", 64'(cyc - cur.hs), 64'd16);
            end
        end else if (o_out_valid && have_cur) begin
            chk("hold_text", o_text, cur.txt);
        end
        if (o_out_valid) chk("in_ready_low_while_valid", 64'(o_in_ready), 64'd0);
        prev_v = o_out_valid;
        cyc++;
    end

    task automatic send(input logic [63:0] key, input logic [63:0] text, input logic dec,
                        input logic [63:0] exp);
        bit ok = 0;
        @(negedge i_clk);
        i_key = key;
        i_text = text;
        i_decrypt = dec;
        i_in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (o_in_ready) begin
                ok = 1;
                break;
            end
            @(negedge i_clk);
        end
        if (ok) begin
            @(posedge i_clk);
            exp_q.push_back('{exp, cyc});
        end else begin
            fail("input_handshake_timeout");
        end
        @(negedge i_clk);
        i_in_valid = 1'b0;
        i_key = {$urandom, $urandom};
        i_text = {$urandom, $urandom};
        i_decrypt = 1'($urandom);
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge i_clk);
            if (exp_q.size() == 0 && !o_out_valid && o_in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail("drain_timeout");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] k, p, c;
        bit ok;

        repeat (2) @(negedge i_clk);
        chk("rst_in_ready", 64'(o_in_ready), 64'd1);
        chk("rst_out_valid", 64'(o_out_valid), 64'd0);
        chk("rst_text", o_text, 64'd0);
        i_rst_n = 1'b1;

        // Known-answer vectors
        send(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405);
        send(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF);
        send(64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7);
        send(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000);
        drain();

        // Reset during round 7: in-flight block is discarded
        send(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0,
             des_model(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0));
        repeat (7) @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("midrun_rst_in_ready", 64'(o_in_ready), 64'd1);
        chk("midrun_rst_out_valid", 64'(o_out_valid), 64'd0);
        chk("midrun_rst_text", o_text, 64'd0);
        void'(exp_q.pop_back());
        @(negedge i_clk);
        i_rst_n = 1'b1;
        send(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405);
        drain();

        // Backpressure, with stray i_in_valid pulses in RUN and DONE
        rdy_mode = 2;
        @(negedge i_clk);
        send(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000);
        repeat (4) @(negedge i_clk);
        i_in_valid = 1'b1;
        i_text = 64'hDEADBEEFCAFEF00D;
        repeat (2) @(negedge i_clk);
        i_in_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail("bp_valid_timeout");
        repeat (3) @(negedge i_clk);
        i_in_valid = 1'b1;
        repeat (2) @(negedge i_clk);
        i_in_valid = 1'b0;
        repeat (5) @(negedge i_clk);
        chk("bp_valid_held", 64'(o_out_valid), 64'd1);
        rdy_mode = 0;
        drain();

        // Random blocks with random output stalls
        rdy_mode = 1;
        for (int n = 0; n < 100; n++) begin
            k = {$urandom, $urandom};
            p = {$urandom, $urandom};
            ok = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
            send(k, p, ok, des_model(k, p, ok));
        end

        // Round trips: decrypt must return the original plaintext
        for (int n = 0; n < 10; n++) begin
            k = {$urandom, $urandom};
            p = {$urandom, $urandom};
            c = des_model(k, p, 1'b0);
            send(k, p, 1'b0, c);
            send(k, c, 1'b1, p);
        end
        drain();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
